// File: rtl/dt_param.sv
// Two-pass chamfer distance transform (chessboard or city-block) of a 1-bit ROM image
// into an external result RAM, with saturating distances.
module dt_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int WORD_W = 16,
  parameter int DIST_W = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   mode,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   sti_rd,
  output logic [$clog2(IMG_W*IMG_H/WORD_W)-1:0]  sti_addr,
  input  logic [WORD_W-1:0]                      sti_di,
  output logic                                   res_rd,
  output logic                                   res_wr,
  output logic [$clog2(IMG_W*IMG_H)-1:0]         res_addr,
  output logic [DIST_W-1:0]                      res_do,
  input  logic [DIST_W-1:0]                      res_di
);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int LW  = $clog2(WORD_W);
  localparam int AW  = CW + RW;
  localparam int SAW = AW - LW;

  localparam logic [RW-1:0]     R_ONE   = RW'(1);
  localparam logic [RW-1:0]     R_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0]     R_BLAST = RW'(IMG_H - 2);
  localparam logic [CW-1:0]     C_ONE   = CW'(1);
  localparam logic [CW-1:0]     C_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     C_BLAST = CW'(IMG_W - 2);
  localparam logic [CW-1:0]     C_LMASK = CW'(WORD_W - 1);
  localparam logic [AW-1:0]     A_ONE   = AW'(1);
  localparam logic [AW-1:0]     A_ROW   = AW'(IMG_W);
  localparam logic [SAW-1:0]    S_ONE   = SAW'(1);
  localparam logic [DIST_W-1:0] D_ONE   = DIST_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD_LOAD, S_FWD_RD, S_FWD_WR, S_BWD_LOAD, S_BWD_RD, S_BWD_WR, S_FINISH
  } state_t;

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] x);
    return (&x) ? x : x + D_ONE;
  endfunction

  function automatic logic [DIST_W-1:0] dmin(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Neighbour offsets in read order: fwd W,NW,N,NE / W,N; bwd self,E,SE,S,SW / self,E,S.
  function automatic logic [AW-1:0] nbr_off(input logic bwd, input logic m, input logic [2:0] k);
    logic [AW-1:0] off;
    off = '0;
    case ({bwd, m, k})
      5'b00_000, 5'b01_000: off = -A_ONE;
      5'b00_001:            off = -(A_ROW + A_ONE);
      5'b00_010, 5'b01_001: off = -A_ROW;
      5'b00_011:            off = A_ONE - A_ROW;
      5'b10_001, 5'b11_001: off = A_ONE;
      5'b10_010:            off = A_ROW + A_ONE;
      5'b10_011, 5'b11_010: off = A_ROW;
      5'b10_100:            off = A_ROW - A_ONE;
      default:              off = '0;
    endcase
    return off;
  endfunction

  state_t              r_state, w_next;
  logic [RW-1:0]       r_r;
  logic [CW-1:0]       r_c;
  logic [2:0]          r_k;
  logic                r_rvld, r_ld, r_mode;
  logic [WORD_W-1:0]   r_word;
  logic [DIST_W-1:0]   r_min, r_self;

  logic                w_fwd_rd, w_bwd_rd, w_rd, w_obj, w_issue, w_rd_done, w_wnz;
  logic [2:0]          w_nrd;
  logic [AW-1:0]       w_pix;
  logic [SAW-1:0]      w_waddr;
  logic [LW-1:0]       w_off;
  logic                w_f_last, w_f_wend, w_c_first, w_b_end, w_b_load, w_bw_first, w_bw_end;
  logic [RW-1:0]       w_br_nxt, w_bwr_nxt;
  logic [CW-1:0]       w_bc_nxt, w_bwc_nxt;

  assign w_pix     = {r_r, r_c};
  assign w_waddr   = w_pix[AW-1:LW];
  assign w_off     = ~r_c[LW-1:0];
  assign w_obj     = r_word[w_off] && (r_r != '0) && (r_r != R_LAST) && (r_c != '0) && (r_c != C_LAST);
  assign w_fwd_rd  = (r_state == S_FWD_RD);
  assign w_bwd_rd  = (r_state == S_BWD_RD);
  assign w_rd      = w_fwd_rd || w_bwd_rd;
  assign w_nrd     = w_bwd_rd ? (r_mode ? 3'd3 : 3'd5) : (r_mode ? 3'd2 : 3'd4);
  assign w_rd_done = (r_k == w_nrd);
  assign w_issue   = w_rd && w_obj && !w_rd_done;
  assign w_wnz     = |sti_di;
  assign w_f_last  = (r_r == R_LAST) && (r_c == C_LAST);
  assign w_f_wend  = ((r_c & C_LMASK) == C_LMASK);
  // Backward stepping: per pixel (w_b*) and per skipped all-zero word (w_bw*).
  assign w_c_first  = (r_c == C_ONE);
  assign w_b_end    = w_c_first && (r_r == R_ONE);
  assign w_b_load   = w_c_first || ((r_c & C_LMASK) == '0);
  assign w_br_nxt   = w_c_first ? r_r - R_ONE : r_r;
  assign w_bc_nxt   = w_c_first ? C_BLAST : r_c - C_ONE;
  assign w_bw_first = ((r_c & ~C_LMASK) == '0);
  assign w_bw_end   = w_bw_first && (r_r == R_ONE);
  assign w_bwr_nxt  = w_bw_first ? r_r - R_ONE : r_r;
  assign w_bwc_nxt  = w_bw_first ? C_BLAST : (r_c & ~C_LMASK) - C_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_FWD_LOAD;
      S_FWD_LOAD: if (r_ld) w_next = S_FWD_RD;
      S_FWD_RD:   if (!w_obj || w_rd_done) w_next = S_FWD_WR;
      S_FWD_WR:   w_next = w_f_last ? S_BWD_LOAD : (w_f_wend ? S_FWD_LOAD : S_FWD_RD);
      S_BWD_LOAD: if (r_ld) begin
                    if (w_wnz)         w_next = S_BWD_RD;
                    else if (w_bw_end) w_next = S_FINISH;
                  end
      S_BWD_RD:   if (!w_obj)         w_next = w_b_end ? S_FINISH : (w_b_load ? S_BWD_LOAD : S_BWD_RD);
                  else if (w_rd_done) w_next = S_BWD_WR;
      S_BWD_WR:   w_next = w_b_end ? S_FINISH : (w_b_load ? S_BWD_LOAD : S_BWD_RD);
      S_FINISH:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_FINISH);
    sti_rd   = 1'b0;
    sti_addr = '0;
    res_rd   = 1'b0;
    res_wr   = 1'b0;
    res_addr = '0;
    res_do   = '0;
    case (r_state)
      S_FWD_LOAD: begin
        sti_rd   = !r_ld;
        sti_addr = w_waddr;
      end
      S_BWD_LOAD: begin
        sti_rd   = !r_ld || (!w_wnz && !w_bw_end);
        sti_addr = r_ld ? w_waddr - S_ONE : w_waddr;
      end
      S_FWD_RD, S_BWD_RD: if (w_issue) begin
        res_rd   = 1'b1;
        res_addr = w_pix + nbr_off(w_bwd_rd, r_mode, r_k);
      end
      S_FWD_WR: begin
        res_wr   = 1'b1;
        res_addr = w_pix;
        res_do   = w_obj ? sat_inc(r_min) : '0;
      end
      S_BWD_WR: begin
        res_wr   = 1'b1;
        res_addr = w_pix;
        res_do   = dmin(r_self, sat_inc(r_min));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r    <= '0;
      r_c    <= '0;
      r_k    <= '0;
      r_rvld <= 1'b0;
      r_ld   <= 1'b0;
      r_mode <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mode <= mode;
          r_r    <= '0;
          r_c    <= '0;
          r_k    <= '0;
          r_rvld <= 1'b0;
          r_ld   <= 1'b0;
        end
        S_FWD_LOAD: begin
          r_ld   <= !r_ld;
          r_k    <= '0;
          r_rvld <= 1'b0;
        end
        S_FWD_RD: begin
          r_k    <= w_issue ? r_k + 3'd1 : r_k;
          r_rvld <= w_issue;
        end
        S_FWD_WR: begin
          r_k    <= '0;
          r_rvld <= 1'b0;
          r_ld   <= 1'b0;
          if (w_f_last) begin
            r_r <= R_BLAST;
            r_c <= C_BLAST;
          end else begin
            r_c <= r_c + C_ONE;
            if (r_c == C_LAST) r_r <= r_r + R_ONE;
          end
        end
        S_BWD_LOAD: begin
          r_k    <= '0;
          r_rvld <= 1'b0;
          if (!r_ld)      r_ld <= 1'b1;
          else if (w_wnz) r_ld <= 1'b0;
          else begin
            r_r <= w_bwr_nxt;
            r_c <= w_bwc_nxt;
          end
        end
        S_BWD_RD: begin
          r_k    <= w_issue ? r_k + 3'd1 : r_k;
          r_rvld <= w_issue;
          if (!w_obj) begin
            r_r <= w_br_nxt;
            r_c <= w_bc_nxt;
          end
        end
        S_BWD_WR: begin
          r_k    <= '0;
          r_rvld <= 1'b0;
          r_r    <= w_br_nxt;
          r_c    <= w_bc_nxt;
        end
        default: ;
      endcase
    end
  end

  // Read data lands one cycle after its strobe; the first backward read is the pixel itself.
  always_ff @(posedge clk) begin
    if ((r_state == S_FWD_LOAD || r_state == S_BWD_LOAD) && r_ld) r_word <= sti_di;
    if (w_rd) begin
      if (r_rvld) begin
        if (w_bwd_rd && r_k == 3'd1) r_self <= res_di;
        else                         r_min  <= dmin(r_min, res_di);
      end
    end else begin
      r_min <= '1;
    end
  end

endmodule
